// File: rtl/mc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer_if
//  Purpose  : Control/flag bundle between the multicycle sequencer and datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_sequencer_if #(
    parameter int EXC_W = 3
);
    // datapath -> sequencer
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             ov;
    logic             eq;
    logic             md_done;
    logic             md_dz;
    // sequencer -> datapath
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_write;
    logic             ab_write;
    logic [2:0]       alu_op;
    logic [1:0]       alu_srcb;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic             md_start;
    logic             md_op;
    logic             epc_write;
    logic [EXC_W-1:0] exc_code;
    logic             halted;

    modport master (
        input  opcode, funct, ov, eq, md_done, md_dz,
        output pc_write, pc_src, iord, mem_rd, mem_wr, ir_write, ab_write,
               alu_op, alu_srcb, reg_write, reg_dst, md_start, md_op,
               epc_write, exc_code, halted
    );

    modport slave (
        output opcode, funct, ov, eq, md_done, md_dz,
        input  pc_write, pc_src, iord, mem_rd, mem_wr, ir_write, ab_write,
               alu_op, alu_srcb, reg_write, reg_dst, md_start, md_op,
               epc_write, exc_code, halted
    );
endinterface
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_sequencer
//  Purpose  : Multicycle fetch/decode/execute control FSM for the MIPS-subset
//             datapath, with memory wait states, mult/div timeout and EPC.
//  Revision : 1.0  initial release
// ============================================================================
module mc_sequencer #(
    parameter int MEM_WAIT   = 1,
    parameter int MD_TIMEOUT = 40,
    parameter int EXC_W      = 3
) (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.master bus
);
    localparam int c_md_cw = $clog2(MD_TIMEOUT);
    localparam logic [3:0]         c_mem_last = 4'(MEM_WAIT);
    localparam logic [c_md_cw-1:0] c_md_last  = c_md_cw'(MD_TIMEOUT - 1);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0a;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2b;

    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_break = 6'h0d;
    localparam logic [5:0] c_fn_mult  = 6'h18;
    localparam logic [5:0] c_fn_div   = 6'h1a;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_slt   = 6'h2a;

    localparam logic [2:0] c_alu_add = 3'd0;
    localparam logic [2:0] c_alu_sub = 3'd1;
    localparam logic [2:0] c_alu_and = 3'd2;
    localparam logic [2:0] c_alu_slt = 3'd3;

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_LATCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
        S_MD_START, S_MD_WAIT, S_EXC, S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_mem_cnt;
    logic [c_md_cw-1:0] r_md_cnt;
    logic [EXC_W-1:0]   r_exc_code;
    logic               r_halted;
    logic [EXC_W-1:0]   w_exc_nxt;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_is_r;
    logic       w_mem_last;

    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_iord;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_ir_write;
    logic       w_ab_write;
    logic [2:0] w_alu_op;
    logic [1:0] w_alu_srcb;
    logic       w_reg_write;
    logic [1:0] w_reg_dst;
    logic       w_md_start;
    logic       w_md_op;
    logic       w_epc_write;

    assign w_opcode = bus.opcode;
    assign w_funct  = bus.funct;
    assign w_is_r   = (w_opcode == c_op_rtype);
    // Address phase spans two cycles so ALUOut is settled before the strobe.
    assign w_mem_last = (r_mem_cnt == ((r_state == S_MEM_ADDR) ? 4'd1 : c_mem_last));

    always_comb begin
        w_state_nxt = r_state;
        w_exc_nxt   = '0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        w_iord      = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_ir_write  = 1'b0;
        w_ab_write  = 1'b0;
        w_alu_op    = c_alu_add;
        w_alu_srcb  = 2'd0;
        w_reg_write = 1'b0;
        w_reg_dst   = 2'd0;
        w_md_start  = 1'b0;
        w_md_op     = 1'b0;
        w_epc_write = 1'b0;
        case (r_state)
            S_RST: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (w_mem_last) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_ir_write  = 1'b1;
                w_alu_srcb  = 2'd1;
                w_pc_write  = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_ab_write = 1'b1;
                w_alu_srcb = 2'd3;
                if (w_is_r) begin
                    case (w_funct)
                        c_fn_add, c_fn_sub, c_fn_and, c_fn_slt: w_state_nxt = S_EXEC_R;
                        c_fn_mult, c_fn_div:                    w_state_nxt = S_MD_START;
                        c_fn_jr:                                w_state_nxt = S_JUMP;
                        c_fn_break:                             w_state_nxt = S_HALT;
                        default: begin
                            w_state_nxt = S_EXC;
                            w_exc_nxt   = EXC_W'(1);
                        end
                    endcase
                end else begin
                    case (w_opcode)
                        c_op_addi, c_op_slti: w_state_nxt = S_EXEC_I;
                        c_op_lw, c_op_sw:     w_state_nxt = S_MEM_ADDR;
                        c_op_beq, c_op_bne:   w_state_nxt = S_BRANCH;
                        c_op_j, c_op_jal:     w_state_nxt = S_JUMP;
                        default: begin
                            w_state_nxt = S_EXC;
                            w_exc_nxt   = EXC_W'(1);
                        end
                    endcase
                end
            end
            S_EXEC_R: begin
                case (w_funct)
                    c_fn_sub: w_alu_op = c_alu_sub;
                    c_fn_and: w_alu_op = c_alu_and;
                    c_fn_slt: w_alu_op = c_alu_slt;
                    default:  w_alu_op = c_alu_add;
                endcase
                if (bus.ov && (w_funct == c_fn_add || w_funct == c_fn_sub)) begin
                    w_state_nxt = S_EXC;
                    w_exc_nxt   = EXC_W'(2);
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_EXEC_I: begin
                w_alu_srcb = 2'd2;
                w_alu_op   = (w_opcode == c_op_slti) ? c_alu_slt : c_alu_add;
                if (bus.ov && w_opcode == c_op_addi) begin
                    w_state_nxt = S_EXC;
                    w_exc_nxt   = EXC_W'(2);
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = w_is_r ? 2'd1 : 2'd0;
                w_state_nxt = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_srcb = 2'd2;
                if (w_mem_last) w_state_nxt = (w_opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_rd = 1'b1;
                w_iord   = 1'b1;
                if (w_mem_last) w_state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_wr = 1'b1;
                w_iord   = 1'b1;
                if (w_mem_last) w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_op    = c_alu_sub;
                w_pc_src    = 2'd1;
                w_pc_write  = ((w_opcode == c_op_beq) && bus.eq) ||
                              ((w_opcode == c_op_bne) && !bus.eq);
                w_state_nxt = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = 2'd2;
                w_pc_write = 1'b1;
                if (w_opcode == c_op_jal) begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 2'd2;
                end
                w_state_nxt = S_FETCH;
            end
            S_MD_START: begin
                w_md_start  = 1'b1;
                w_md_op     = (w_funct == c_fn_div);
                w_state_nxt = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                w_md_op = (w_funct == c_fn_div);
                // A completion on the final allowed cycle beats the timeout.
                if (bus.md_done) begin
                    if (bus.md_dz && w_funct == c_fn_div) begin
                        w_state_nxt = S_EXC;
                        w_exc_nxt   = EXC_W'(3);
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else if (r_md_cnt == c_md_last) begin
                    w_state_nxt = S_EXC;
                    w_exc_nxt   = EXC_W'(4);
                end
            end
            S_EXC: begin
                w_epc_write = 1'b1;
                w_pc_src    = 2'd3;
                w_pc_write  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RST;
            r_mem_cnt  <= 4'd0;
            r_md_cnt   <= '0;
            r_exc_code <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_mem_cnt <= 4'd0;
            end else if (r_state == S_FETCH || r_state == S_MEM_ADDR ||
                         r_state == S_MEM_RD || r_state == S_MEM_WR) begin
                r_mem_cnt <= r_mem_cnt + 4'd1;
            end
            if (r_state == S_MD_START) begin
                r_md_cnt <= '0;
            end else if (r_state == S_MD_WAIT && w_state_nxt == S_MD_WAIT) begin
                r_md_cnt <= r_md_cnt + 1'b1;
            end
            if (w_state_nxt == S_EXC)  r_exc_code <= w_exc_nxt;
            if (w_state_nxt == S_HALT) r_halted   <= 1'b1;
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.pc_src    = w_pc_src;
    assign bus.iord      = w_iord;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.ir_write  = w_ir_write;
    assign bus.ab_write  = w_ab_write;
    assign bus.alu_op    = w_alu_op;
    assign bus.alu_srcb  = w_alu_srcb;
    assign bus.reg_write = w_reg_write;
    assign bus.reg_dst   = w_reg_dst;
    assign bus.md_start  = w_md_start;
    assign bus.md_op     = w_md_op;
    assign bus.epc_write = w_epc_write;
    assign bus.exc_code  = r_exc_code;
    assign bus.halted    = r_halted;
endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_sequencer
//  Purpose  : Directed self-checking bench for mc_sequencer (W=1 and W=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mc_sequencer_if #(.EXC_W(3)) if1 ();
    mc_sequencer_if #(.EXC_W(3)) if3 ();

    mc_sequencer #(.MEM_WAIT(1), .MD_TIMEOUT(40), .EXC_W(3)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    mc_sequencer #(.MEM_WAIT(3), .MD_TIMEOUT(40), .EXC_W(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3)
    );

    function automatic logic [22:0] outs1();
        return {if1.pc_write, if1.pc_src, if1.iord, if1.mem_rd, if1.mem_wr,
                if1.ir_write, if1.ab_write, if1.alu_op, if1.alu_srcb,
                if1.reg_write, if1.reg_dst, if1.md_start, if1.md_op,
                if1.epc_write, if1.exc_code, if1.halted};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH cycle 1 (W=1) to the DECODE cycle (cycle 4).
    task automatic to_decode1();
        repeat (3) step();
    endtask

    task automatic test_reset();
        if1.opcode = 6'h00; if1.funct = 6'h20; if1.ov = 1'b0; if1.eq = 1'b0;
        if1.md_done = 1'b0; if1.md_dz = 1'b0;
        if3.opcode = 6'h23; if3.funct = 6'h00; if3.ov = 1'b0; if3.eq = 1'b0;
        if3.md_done = 1'b0; if3.md_dz = 1'b0;
        repeat (2) step();
        n_tests++; if (outs1() !== 23'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", outs1()); end
        reset = 1'b1;
        n_tests++; if (outs1() !== 23'd0) begin n_fail++; $display("FAIL rst_state_outs: got %h want 0", outs1()); end
        step();
        n_tests++; if ({if1.mem_rd, if1.iord} !== 2'b10) begin n_fail++; $display("FAIL fetch_c1 mem_rd/iord: got %b want 10", {if1.mem_rd, if1.iord}); end
        step();
        n_tests++; if (if1.mem_rd !== 1'b1) begin n_fail++; $display("FAIL fetch_c2 mem_rd: got %b want 1", if1.mem_rd); end
        step();
        n_tests++; if ({if1.mem_rd, if1.ir_write, if1.pc_write, if1.pc_src, if1.alu_srcb, if1.alu_op} !== {1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 3'd0}) begin
            n_fail++; $display("FAIL latch_ctl: got %b want 0110001000", {if1.mem_rd, if1.ir_write, if1.pc_write, if1.pc_src, if1.alu_srcb, if1.alu_op});
        end
    endtask

    task automatic test_add_ok();
        step();
        n_tests++; if ({if1.ab_write, if1.alu_srcb} !== 3'b111) begin n_fail++; $display("FAIL decode_ctl: got %b want 111", {if1.ab_write, if1.alu_srcb}); end
        step();
        n_tests++; if ({if1.alu_op, if1.alu_srcb, if1.reg_write} !== 6'b000000) begin n_fail++; $display("FAIL add_exec: got %b want 000000", {if1.alu_op, if1.alu_srcb, if1.reg_write}); end
        step();
        n_tests++; if ({if1.reg_write, if1.reg_dst} !== 3'b101) begin n_fail++; $display("FAIL add_wb c6: got %b want 101", {if1.reg_write, if1.reg_dst}); end
        step();
    endtask

    task automatic test_add_ov();
        if1.opcode = 6'h00; if1.funct = 6'h20;
        to_decode1();
        if1.ov = 1'b1;
        step();
        n_tests++; if (if1.reg_write !== 1'b0) begin n_fail++; $display("FAIL add_ov_exec reg_write: got %b want 0", if1.reg_write); end
        step();
        if1.ov = 1'b0;
        n_tests++; if ({if1.epc_write, if1.pc_src, if1.pc_write, if1.exc_code, if1.reg_write} !== {1'b1, 2'd3, 1'b1, 3'd2, 1'b0}) begin
            n_fail++; $display("FAIL add_ov_exc: got %b want 11110100", {if1.epc_write, if1.pc_src, if1.pc_write, if1.exc_code, if1.reg_write});
        end
        step();
        n_tests++; if ({if1.mem_rd, if1.exc_code} !== 4'b1010) begin n_fail++; $display("FAIL add_ov_held: got %b want 1010", {if1.mem_rd, if1.exc_code}); end
    endtask

    task automatic test_slti_ov();
        if1.opcode = 6'h0a; if1.funct = 6'h00;
        to_decode1();
        if1.ov = 1'b1;
        step();
        n_tests++; if ({if1.alu_op, if1.alu_srcb} !== 5'b01110) begin n_fail++; $display("FAIL slti_exec: got %b want 01110", {if1.alu_op, if1.alu_srcb}); end
        step();
        if1.ov = 1'b0;
        n_tests++; if ({if1.reg_write, if1.reg_dst, if1.epc_write} !== 4'b1000) begin n_fail++; $display("FAIL slti_wb: got %b want 1000", {if1.reg_write, if1.reg_dst, if1.epc_write}); end
        step();
        n_tests++; if (if1.exc_code !== 3'd2) begin n_fail++; $display("FAIL slti_exc_held: got %0d want 2", if1.exc_code); end
    endtask

    task automatic test_branch_jump();
        if1.opcode = 6'h04; if1.eq = 1'b1;
        to_decode1();
        step();
        n_tests++; if ({if1.pc_write, if1.pc_src, if1.alu_op} !== 6'b101001) begin n_fail++; $display("FAIL beq_taken: got %b want 101001", {if1.pc_write, if1.pc_src, if1.alu_op}); end
        step();
        n_tests++; if (if1.mem_rd !== 1'b1) begin n_fail++; $display("FAIL beq_refetch mem_rd: got %b want 1", if1.mem_rd); end
        if1.opcode = 6'h05;
        to_decode1();
        step();
        n_tests++; if ({if1.pc_write, if1.pc_src} !== 3'b001) begin n_fail++; $display("FAIL bne_not_taken: got %b want 001", {if1.pc_write, if1.pc_src}); end
        step();
        if1.eq = 1'b0;
        n_tests++; if (if1.mem_rd !== 1'b1) begin n_fail++; $display("FAIL bne_refetch mem_rd: got %b want 1", if1.mem_rd); end
        if1.opcode = 6'h03;
        to_decode1();
        step();
        n_tests++; if ({if1.pc_write, if1.pc_src, if1.reg_write, if1.reg_dst} !== 6'b110110) begin n_fail++; $display("FAIL jal_ctl: got %b want 110110", {if1.pc_write, if1.pc_src, if1.reg_write, if1.reg_dst}); end
        step();
    endtask

    task automatic test_sw_abort();
        if1.opcode = 6'h2b;
        to_decode1();
        step();
        n_tests++; if ({if1.alu_srcb, if1.alu_op, if1.mem_wr} !== 6'b100000) begin n_fail++; $display("FAIL sw_addr: got %b want 100000", {if1.alu_srcb, if1.alu_op, if1.mem_wr}); end
        step();
        n_tests++; if (if1.mem_wr !== 1'b0) begin n_fail++; $display("FAIL sw_addr2 mem_wr: got %b want 0", if1.mem_wr); end
        for (int c = 7; c <= 8; c++) begin
            step();
            n_tests++; if ({if1.mem_wr, if1.iord, if1.mem_rd} !== 3'b110) begin n_fail++; $display("FAIL sw_write c%0d: got %b want 110", c, {if1.mem_wr, if1.iord, if1.mem_rd}); end
        end
        step();
        n_tests++; if ({if1.mem_wr, if1.mem_rd, if1.iord} !== 3'b010) begin n_fail++; $display("FAIL sw_refetch: got %b want 010", {if1.mem_wr, if1.mem_rd, if1.iord}); end
        to_decode1();
        repeat (3) step();
        reset = 1'b0;
        #1;
        n_tests++; if (outs1() !== 23'd0) begin n_fail++; $display("FAIL abort_outs: got %h want 0", outs1()); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_md();
        if1.opcode = 6'h00; if1.funct = 6'h1a;
        to_decode1();
        step();
        n_tests++; if ({if1.md_start, if1.md_op} !== 2'b11) begin n_fail++; $display("FAIL div_start: got %b want 11", {if1.md_start, if1.md_op}); end
        step();
        n_tests++; if (if1.md_start !== 1'b0) begin n_fail++; $display("FAIL div_start_pulse: got %b want 0", if1.md_start); end
        step();
        step();
        if1.md_done = 1'b1; if1.md_dz = 1'b1;
        step();
        if1.md_done = 1'b0;
        n_tests++; if ({if1.epc_write, if1.pc_src, if1.exc_code} !== 6'b111011) begin n_fail++; $display("FAIL div_dz_exc: got %b want 111011", {if1.epc_write, if1.pc_src, if1.exc_code}); end
        step();
        // mult completing with md_dz set must not trap
        if1.funct = 6'h18;
        to_decode1();
        step();
        step();
        if1.md_done = 1'b1;
        step();
        if1.md_done = 1'b0; if1.md_dz = 1'b0;
        n_tests++; if ({if1.mem_rd, if1.epc_write, if1.exc_code} !== 5'b10011) begin n_fail++; $display("FAIL mult_done: got %b want 10011", {if1.mem_rd, if1.epc_write, if1.exc_code}); end
        to_decode1();
        step();
        n_tests++; if ({if1.md_start, if1.md_op} !== 2'b10) begin n_fail++; $display("FAIL mult_start: got %b want 10", {if1.md_start, if1.md_op}); end
        repeat (40) step();
        n_tests++; if ({if1.epc_write, if1.mem_rd, if1.md_start} !== 3'b000) begin n_fail++; $display("FAIL md_wait_last: got %b want 000", {if1.epc_write, if1.mem_rd, if1.md_start}); end
        step();
        n_tests++; if ({if1.epc_write, if1.pc_src, if1.exc_code} !== 6'b111100) begin n_fail++; $display("FAIL md_timeout_exc: got %b want 111100", {if1.epc_write, if1.pc_src, if1.exc_code}); end
        step();
        to_decode1();
        step();
        repeat (40) step();
        if1.md_done = 1'b1;
        step();
        if1.md_done = 1'b0;
        n_tests++; if ({if1.mem_rd, if1.epc_write, if1.exc_code} !== 5'b10100) begin n_fail++; $display("FAIL md_done_wins: got %b want 10100", {if1.mem_rd, if1.epc_write, if1.exc_code}); end
    endtask

    task automatic test_illegal_halt();
        if1.opcode = 6'h3f; if1.funct = 6'h00;
        to_decode1();
        step();
        n_tests++; if ({if1.epc_write, if1.pc_src, if1.pc_write, if1.exc_code} !== 7'b1111001) begin n_fail++; $display("FAIL illegal_exc: got %b want 1111001", {if1.epc_write, if1.pc_src, if1.pc_write, if1.exc_code}); end
        step();
        if1.opcode = 6'h00; if1.funct = 6'h0d;
        to_decode1();
        step();
        n_tests++; if ({if1.halted, if1.mem_rd, if1.pc_write} !== 3'b100) begin n_fail++; $display("FAIL halt_enter: got %b want 100", {if1.halted, if1.mem_rd, if1.pc_write}); end
        repeat (6) step();
        n_tests++; if (outs1() !== 23'd3) begin n_fail++; $display("FAIL halt_sticky: got %h want 3", outs1()); end
        reset = 1'b0;
        #1;
        n_tests++; if ({if1.halted, if1.exc_code} !== 4'b0000) begin n_fail++; $display("FAIL halt_reset_clear: got %b want 0000", {if1.halted, if1.exc_code}); end
        if1.funct = 6'h20;
        step();
        reset = 1'b1;
        step();
        n_tests++; if ({if1.halted, if1.mem_rd} !== 2'b01) begin n_fail++; $display("FAIL halt_restart: got %b want 01", {if1.halted, if1.mem_rd}); end
    endtask

    task automatic test_lw_w3();
        logic exp_rd;
        logic exp_wr;
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            exp_rd = (c <= 4) || (c >= 9 && c <= 12) || (c == 14);
            exp_wr = (c == 13);
            n_tests++; if ({if3.mem_rd, if3.reg_write} !== {exp_rd, exp_wr}) begin
                n_fail++; $display("FAIL lw_w3 c%0d mem_rd/reg_write: got %b want %b", c, {if3.mem_rd, if3.reg_write}, {exp_rd, exp_wr});
            end
            if (c == 10) begin
                n_tests++; if (if3.iord !== 1'b1) begin n_fail++; $display("FAIL lw_w3 iord: got %b want 1", if3.iord); end
            end
            if (c == 13) begin
                n_tests++; if (if3.reg_dst !== 2'd0) begin n_fail++; $display("FAIL lw_w3 reg_dst: got %0d want 0", if3.reg_dst); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ok();
        test_add_ov();
        test_slti_ov();
        test_branch_jump();
        test_sw_abort();
        test_md();
        test_illegal_halt();
        test_lw_w3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
